fmi_dma_ctrl: RTL and testbench
===============================

FMI_DMA_CTRL -- requirements
Module: fmi_dma_ctrl

Interface
REQ-001 Parameters: none; FMI_N_ELEM (FMI depth) and PX_W (pixel width) come from ram_pkg; AW = $clog2(FMI_N_ELEM).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  command pulse, sampled only in IDLE.
REQ-005 mode  in  1  0 = LOAD (stream to FMI RAM), 1 = DRAIN (FMI RAM to stream); sampled with start.
REQ-006 base  in  AW  first FMI address; sampled with start.
REQ-007 len  in  AW+1  pixel count, 0..FMI_N_ELEM; sampled with start.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  range error flag; cleared on the next accepted start.
REQ-011 s_valid / s_data / s_ready  in / in PX_W / out  LOAD input stream.
REQ-012 m_valid / m_data / m_ready  out / out PX_W / in  DRAIN output stream.
REQ-013 ram_addr / ram_data / ram_write  out AW / out PX_W / out 1  FMI RAM port.
REQ-014 ram_res  in  PX_W  FMI RAM read data; valid one cycle after ram_addr is presented.

Function
REQ-015 States SHALL be IDLE, LOAD, DRAIN and DONE.
REQ-016 In IDLE, start=1 SHALL load the address counter with base and the remaining count with len, clear err, and enter LOAD or DRAIN according to mode.
REQ-017 If base+len > FMI_N_ELEM (AW+2-bit compare), start SHALL set err, perform no RAM access, and enter DONE.
REQ-018 If len = 0, start SHALL enter DONE directly with err=0.
REQ-019 In LOAD, s_ready SHALL be 1; on each s_valid&s_ready cycle, ram_write=1, ram_addr=current address and ram_data=s_data combinationally; the address increments and the count decrements.
REQ-020 LOAD SHALL enter DONE on the cycle after the last handshake; s_ready SHALL be 0 outside LOAD.
REQ-021 In DRAIN, a read SHALL be issued (ram_addr=address, ram_write=0) only when buffered entries plus in-flight reads < 2 and reads remain.
REQ-022 ram_res of an issued read SHALL be captured into a 2-entry FIFO on the next edge; m_valid/m_data SHALL present the FIFO head.
REQ-023 On each m_valid&m_ready cycle, the head SHALL pop; a pop and a capture in the same cycle SHALL both take effect.
REQ-024 Pixels SHALL leave in ascending address order without loss or duplication under any m_ready pattern; m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-025 DRAIN SHALL enter DONE once all len pixels have popped.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 ram_write SHALL be 0 and ram_addr SHALL be 0 whenever no access is issued.
REQ-029 Throughput: LOAD 1 pixel/cycle; DRAIN 1 pixel/cycle with m_ready held high, first m_valid in the 3rd cycle after the start cycle.

Reset
REQ-030 On rst_n=0, the state SHALL go to IDLE and busy, done, err, s_ready, m_valid and ram_write SHALL be 0; ram_addr, ram_data and m_data SHALL be 0; the FIFO and counters SHALL be cleared.
REQ-031 Reset mid-transfer SHALL abort the transfer with no further RAM writes; the RAM contents are unaffected.

Structure
REQ-032 The state enum and the FIFO depth constant (2) SHALL live in ram_pkg beside FMI_N_ELEM and PX_W.
REQ-033 The 2-entry FIFO SHALL be a sub-module named fmi_skid_fifo.

Verification
REQ-034 LOAD base=4, len=3, s_valid always high, data 0xA,0xB,0xC -> writes at addr 4,5,6 in consecutive cycles; done pulses in the following cycle.
REQ-035 DRAIN base=4, len=3 against a RAM model, m_ready=1 -> m_data 0xA,0xB,0xC in cycles 3,4,5 after start; single done pulse.
REQ-036 DRAIN len=5, m_ready toggling 1,0,0,1,... -> in-order output with no loss or duplication; m_data stable while stalled; at most 2 outstanding.
REQ-037 base=FMI_N_ELEM-2, len=3 -> err=1 and done on the next cycle, no ram_write; the next valid start clears err.
REQ-038 rst_n pulled low after the 2nd LOAD handshake -> all outputs 0 immediately, no further writes; a following start with len=0 -> done after 1 cycle.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared FMI RAM geometry, DMA state encoding and skid-FIFO sizing.
package ram_pkg;
    localparam int FMI_N_ELEM = 16;
    localparam int PX_W       = 8;
    localparam int AW         = $clog2(FMI_N_ELEM);
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } dma_state_e;
endpackage

// File: rtl/fmi_dma_ctrl_if.sv
// Pixel streams and FMI RAM port of the DMA controller; master is the controller side.
interface fmi_dma_ctrl_if;
    import ram_pkg::*;

    logic            s_valid;
    logic [PX_W-1:0] s_data;
    logic            s_ready;
    logic            m_valid;
    logic [PX_W-1:0] m_data;
    logic            m_ready;
    logic [AW-1:0]   ram_addr;
    logic [PX_W-1:0] ram_data;
    logic            ram_write;
    logic [PX_W-1:0] ram_res;

    modport master (
        input  s_valid, s_data, m_ready, ram_res,
        output s_ready, m_valid, m_data, ram_addr, ram_data, ram_write
    );

    modport slave (
        output s_valid, s_data, m_ready, ram_res,
        input  s_ready, m_valid, m_data, ram_addr, ram_data, ram_write
    );
endinterface

// File: rtl/fmi_skid_fifo.sv
// Two-entry FIFO holding RAM read results until the DRAIN stream accepts them.
module fmi_skid_fifo
    import ram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [PX_W-1:0]    push_data,
    input  logic               pop,
    output logic [FIFO_CW-1:0] count,
    output logic               head_valid,
    output logic [PX_W-1:0]    head_data
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PX_W-1:0]    slot_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [FIFO_CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) slot_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + FIFO_CW'(push) - FIFO_CW'(pop);
        end
    end

    assign count      = cnt_q;
    assign head_valid = (cnt_q != '0);
    assign head_data  = head_valid ? slot_q[rd_ptr_q] : '0;
endmodule

// File: rtl/fmi_dma_ctrl.sv
// FMI DMA controller: writes a pixel stream into the FMI RAM (LOAD) or reads a
// range back out through a 2-deep skid FIFO (DRAIN).
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start; mode/base/len sampled here
// ST_LOAD  | s_ready high, one RAM write per s_* handshake
// ST_DRAIN | issuing RAM reads, streaming the FIFO head on m_*
// ST_DONE  | one-cycle done pulse, then back to IDLE
module fmi_dma_ctrl
    import ram_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    input  logic [AW-1:0]  base,
    input  logic [AW:0]    len,
    output logic           busy,
    output logic           done,
    output logic           err,
    fmi_dma_ctrl_if.master bus
);
    localparam logic [AW+1:0]      N_LIM    = (AW+2)'(FMI_N_ELEM);
    localparam logic [FIFO_CW-1:0] FIFO_LIM = FIFO_CW'(FIFO_DEPTH);

    dma_state_e         state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW:0]        rd_left_q, rd_left_d;
    logic [AW:0]        pop_left_q, pop_left_d;
    logic               err_q, err_d;
    logic               inflight_q, inflight_d;
    logic [AW+1:0]      end_addr;
    logic               range_err;
    logic               fifo_valid;
    logic               fifo_pop;
    logic [PX_W-1:0]    fifo_head;
    logic [FIFO_CW-1:0] fifo_cnt;
    logic [FIFO_CW-1:0] occ_after;

    assign end_addr  = {2'b00, base} + {1'b0, len};
    assign range_err = (end_addr > N_LIM);
    assign fifo_pop  = fifo_valid & bus.m_ready;
    // This cycle's pop is treated as already gone; otherwise a full-rate drain
    // would stall every other cycle waiting for the slot to free up.
    assign occ_after = fifo_cnt - FIFO_CW'(fifo_pop) + FIFO_CW'(inflight_q);

    assign err         = err_q;
    assign bus.m_valid = fifo_valid;
    assign bus.m_data  = fifo_head;

    fmi_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_data  (bus.ram_res),
        .pop        (fifo_pop),
        .count      (fifo_cnt),
        .head_valid (fifo_valid),
        .head_data  (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rd_left_q  <= '0;
            pop_left_q <= '0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_left_q  <= rd_left_d;
            pop_left_q <= pop_left_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_left_d     = rd_left_q;
        pop_left_d    = pop_left_q;
        err_d         = err_q;
        inflight_d    = 1'b0;
        busy          = (state_q != ST_IDLE);
        done          = 1'b0;
        bus.s_ready   = 1'b0;
        bus.ram_write = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_data  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = base;
                    rd_left_d  = len;
                    pop_left_d = len;
                    err_d      = 1'b0;
                    if (range_err) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = mode ? ST_DRAIN : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    bus.ram_write = 1'b1;
                    bus.ram_addr  = addr_q;
                    bus.ram_data  = bus.s_data;
                    addr_d        = addr_q + AW'(1);
                    rd_left_d     = rd_left_q - (AW+1)'(1);
                    if (rd_left_q == (AW+1)'(1)) state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (rd_left_q != '0 && occ_after < FIFO_LIM) begin
                    bus.ram_addr = addr_q;
                    addr_d       = addr_q + AW'(1);
                    rd_left_d    = rd_left_q - (AW+1)'(1);
                    inflight_d   = 1'b1;
                end
                if (fifo_pop) begin
                    pop_left_d = pop_left_q - (AW+1)'(1);
                    if (pop_left_q == (AW+1)'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fmi_dma_ctrl.sv
// Bench for fmi_dma_ctrl: transaction-level model checked every cycle, directed
// literal scenarios plus randomized LOAD/DRAIN traffic.
module tb_fmi_dma_ctrl;
    import ram_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           mode;
    logic [AW-1:0]  base;
    logic [AW:0]    len;
    logic           busy;
    logic           done;
    logic           err;

    fmi_dma_ctrl_if bus();

    fmi_dma_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .base  (base),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: read data appears one cycle after the address.
    logic [PX_W-1:0] mem [FMI_N_ELEM];
    always @(posedge clk) begin
        if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_res <= mem[bus.ram_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 loading, 2 draining, 3 done pulse.
    int              ph = 0;
    int              m_base, m_len, m_k, m_pop;
    logic            m_err = 1'b0;
    logic [PX_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_s_ready", bus.s_ready, 0);
            chk("rst_m_valid", bus.m_valid, 0);
            chk("rst_m_data", bus.m_data, 0);
            chk("rst_ram_write", bus.ram_write, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_ram_data", bus.ram_data, 0);
            ph    = 0;
            m_err = 1'b0;
            exp_q.delete();
        end else begin
            chk("err", err, m_err);
            chk("busy", busy, ph != 0);
            chk("done", done, ph == 3);
            chk("s_ready", bus.s_ready, ph == 1);
            case (ph)
                0: begin
                    chk("idle_m_valid", bus.m_valid, 0);
                    chk("idle_ram_write", bus.ram_write, 0);
                    chk("idle_ram_addr", bus.ram_addr, 0);
                    if (start) begin
                        m_err  = 1'b0;
                        m_base = int'(base);
                        m_len  = int'(len);
                        m_k    = 0;
                        m_pop  = 0;
                        exp_q.delete();
                        if (m_base + m_len > FMI_N_ELEM) begin
                            m_err = 1'b1;
                            ph    = 3;
                        end else if (m_len == 0) begin
                            ph = 3;
                        end else if (!mode) begin
                            ph = 1;
                        end else begin
                            for (int i = 0; i < m_len; i++) exp_q.push_back(mem[m_base + i]);
                            ph = 2;
                        end
                    end
                end
                1: begin
                    chk("load_m_valid", bus.m_valid, 0);
                    if (bus.s_valid) begin
                        chk("load_write", bus.ram_write, 1);
                        chk("load_addr", bus.ram_addr, m_base + m_k);
                        chk("load_data", bus.ram_data, bus.s_data);
                        m_k++;
                        if (m_k == m_len) ph = 3;
                    end else begin
                        chk("load_nowrite", bus.ram_write, 0);
                        chk("load_noaddr", bus.ram_addr, 0);
                    end
                end
                2: begin
                    chk("drain_write", bus.ram_write, 0);
                    if (bus.ram_addr != '0) begin
                        chk("drain_rd_extra", m_k < m_len, 1);
                        chk("drain_rd_addr", bus.ram_addr, m_base + m_k);
                        m_k++;
                    end
                    if (bus.m_valid) begin
                        chk("drain_m_valid_extra", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            chk("drain_m_data", bus.m_data, exp_q[0]);
                            if (bus.m_ready) begin
                                void'(exp_q.pop_front());
                                m_pop++;
                            end
                        end
                    end
                    chk("drain_outstanding", (m_k - m_pop) <= 2, 1);
                    if (m_pop == m_len) ph = 3;
                end
                default: begin
                    chk("done_m_valid", bus.m_valid, 0);
                    chk("done_ram_write", bus.ram_write, 0);
                    chk("done_ram_addr", bus.ram_addr, 0);
                    ph = 0;
                end
            endcase
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // rpat: 0 random m_ready, 1 always ready, 2 ready pattern 1,0,0,...
    task automatic run_cmd(input logic md, input int b, input int l, input int pv,
                           input int rpat, output int pops);
        int c;
        pops  = 0;
        start = 1'b1;
        mode  = md;
        base  = AW'(b);
        len   = (AW+1)'(l);
        nxt();
        start = 1'b0;
        for (c = 0; c < 500 && busy; c++) begin
            bus.s_valid = ($urandom_range(99) < pv);
            bus.s_data  = PX_W'($urandom);
            case (rpat)
                0:       bus.m_ready = 1'($urandom);
                1:       bus.m_ready = 1'b1;
                default: bus.m_ready = (c % 3 == 0);
            endcase
            start = ($urandom_range(7) == 0);
            mode  = 1'($urandom);
            base  = AW'($urandom);
            len   = (AW+1)'($urandom);
            smp();
            if (bus.m_valid && bus.m_ready) pops++;
            nxt();
        end
        start       = 1'b0;
        bus.s_valid = 1'b0;
        chk("run_timeout", busy, 0);
    endtask

    task automatic expect_wr(input string nm, input int a, input int d);
        chk({nm, "_write"}, bus.ram_write, 1);
        chk({nm, "_addr"}, bus.ram_addr, a);
        chk({nm, "_data"}, bus.ram_data, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [PX_W-1:0] snap [4];
    int              np;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        mode        = 1'b0;
        base        = '0;
        len         = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // LOAD base=4 len=3, s_valid held high
        nxt();
        start = 1'b1; mode = 1'b0; base = AW'(4); len = (AW+1)'(3);
        bus.s_valid = 1'b1; bus.s_data = 8'h0A;
        nxt(); start = 1'b0; bus.s_data = 8'h0A;
        smp(); expect_wr("l34_0", 4, 8'h0A);
        nxt(); bus.s_data = 8'h0B;
        smp(); expect_wr("l34_1", 5, 8'h0B);
        nxt(); bus.s_data = 8'h0C;
        smp(); expect_wr("l34_2", 6, 8'h0C);
        nxt(); bus.s_valid = 1'b0;
        smp(); chk("l34_done", done, 1); chk("l34_done_nowrite", bus.ram_write, 0);
        nxt();
        smp(); chk("l34_idle_busy", busy, 0); chk("l34_idle_done", done, 0);

        // DRAIN base=4 len=3 with m_ready high: data in cycles 3,4,5
        nxt();
        start = 1'b1; mode = 1'b1; base = AW'(4); len = (AW+1)'(3); bus.m_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            nxt();
            start = 1'b0;
            smp();
            chk("d35_done", done, c == 6);
            chk("d35_m_valid", bus.m_valid, c >= 3 && c <= 5);
            if (c >= 3 && c <= 5) chk("d35_m_data", bus.m_data, 8'h0A + c - 3);
        end

        // DRAIN len=5 under a 1,0,0 ready pattern
        run_cmd(1'b0, 5, 5, 100, 1, np);
        nxt();
        run_cmd(1'b1, 5, 5, 100, 2, np);
        chk("d36_pops", np, 5);

        // Range error, then a valid zero-length start clears err
        nxt();
        start = 1'b1; mode = 1'b0; base = AW'(FMI_N_ELEM - 2); len = (AW+1)'(3);
        bus.s_valid = 1'b1;
        nxt(); start = 1'b0;
        smp(); chk("e37_done", done, 1); chk("e37_err", err, 1); chk("e37_nowrite", bus.ram_write, 0);
        nxt();
        smp(); chk("e37_err_hold", err, 1); chk("e37_idle", busy, 0);
        nxt(); bus.s_valid = 1'b0;
        start = 1'b1; base = '0; len = '0;
        nxt(); start = 1'b0;
        smp(); chk("e37_err_clr", err, 0); chk("e37_done2", done, 1);

        // Reset after the second LOAD handshake
        nxt();
        for (int i = 0; i < 4; i++) snap[i] = mem[10 + i];
        start = 1'b1; mode = 1'b0; base = AW'(8); len = (AW+1)'(6);
        bus.s_valid = 1'b1; bus.s_data = 8'h55;
        nxt(); start = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b0;
        #1;
        chk("r38_busy", busy, 0);
        chk("r38_s_ready", bus.s_ready, 0);
        chk("r38_ram_write", bus.ram_write, 0);
        chk("r38_ram_addr", bus.ram_addr, 0);
        nxt();
        nxt();
        for (int i = 0; i < 4; i++) chk("r38_mem_kept", mem[10 + i], snap[i]);
        rst_n = 1'b1;
        bus.s_valid = 1'b0;
        nxt();
        start = 1'b1; base = '0; len = '0;
        nxt(); start = 1'b0;
        smp(); chk("r38_done", done, 1);
        nxt();
        smp(); chk("r38_done_once", done, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic md;
            int   b, l;
            md = 1'($urandom);
            b  = $urandom_range(FMI_N_ELEM - 1);
            if (md && b == 0) b = 1;
            l = ($urandom_range(3) != 0) ? $urandom_range(FMI_N_ELEM - b) : $urandom_range(FMI_N_ELEM);
            nxt();
            run_cmd(md, b, l, $urandom_range(100, 30), 0, np);
            repeat ($urandom_range(2)) nxt();
        end

        repeat (2) nxt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
